// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Purpose  : Shared CPU definitions for the iterative divider.
//            Holds the datapath width, the counter width and the state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;

  // Counter value of the final RUN step (32 steps numbered 0..31)
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : Multi-cycle restoring radix-2 divider for DIV / DIVU.
//            Produces {remainder, quotient} with a one-cycle done pulse.
//            The computation runs on operand magnitudes, and signs are
//            applied at the output.
// Revision : 1.0 - initial release
// ============================================================================
module divider
  import divider_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    signed_div_i,
  input  logic [DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]   divisor_i,
  input  logic                    annul_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;

  div_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // {partial remainder[32:0], quotient / remaining dividend bits[31:0]}
  logic [2*W:0]         pr_q, pr_d;
  logic [W-1:0]         dvsr_q, dvsr_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;

  logic [W-1:0]         a_mag, b_mag;
  logic [W+1:0]         rem_sh;
  logic [W+1:0]         diff;
  logic [2*W:0]         pr_step;
  logic [W-1:0]         quo_fix, rem_fix;

  // Operand magnitudes; in unsigned mode the raw value is used as-is
  assign a_mag = (signed_div_i && dividend_i[W-1]) ? (~dividend_i + 1'b1) : dividend_i;
  assign b_mag = (signed_div_i && divisor_i[W-1])  ? (~divisor_i + 1'b1)  : divisor_i;

  // One restoring step: shift the next dividend bit into the remainder, then
  // keep the difference only if it did not go negative
  assign rem_sh  = {pr_q[2*W:W], pr_q[W-1]};
  assign diff    = rem_sh - {2'b00, dvsr_q};
  assign pr_step = diff[W+1] ? {rem_sh[W:0], pr_q[W-2:0], 1'b0}
                             : {diff[W:0],   pr_q[W-2:0], 1'b1};

  // Sign correction applied only to the presented result
  assign quo_fix = qneg_q ? (~pr_q[W-1:0] + 1'b1)    : pr_q[W-1:0];
  assign rem_fix = rneg_q ? (~pr_q[2*W-1:W] + 1'b1)  : pr_q[2*W-1:W];

  // State and datapath registers; reset clears every stored operand
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // Next-state, operand capture and iteration control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = (divisor_i == '0) ? S_ZERO : S_RUN;
            cnt_d   = '0;
            dvsr_d  = b_mag;
            // A zero divisor loads an all-zero register so the result is 0
            pr_d    = (divisor_i == '0) ? '0 : {{(W+1){1'b0}}, a_mag};
            qneg_d  = signed_div_i & (dividend_i[W-1] ^ divisor_i[W-1]);
            rneg_d  = signed_div_i & dividend_i[W-1];
          end
        end
        S_RUN: begin
          pr_d  = pr_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_END;
          end
        end
        S_ZERO:  state_d = S_END;
        S_END:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: result is visible only during the done pulse
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_END) && !annul_i;
    result_o = '0;
    if (done_o) begin
      result_o = {rem_fix, quo_fix};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Purpose  : Scoreboard bench for the divider. An acceptance tracker queues
//            the expected result and completion cycle of every accepted
//            request. A monitor compares the queued values against each done
//            pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [63:0] res;
    int unsigned exp_cyc;
  } exp_t;

  exp_t sb[$];

  divider dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .signed_div_i (signed_div),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .annul_i      (annul),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 64-bit arithmetic truncated to 32 bits
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint qa, qb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
    end else begin
      qa = longint'({32'd0, a});
      qb = longint'({32'd0, b});
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance tracker: a request is taken at the next edge when idle and not annulled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        sb.delete();
      end else if (annul && busy) begin
        if (sb.size() > 0) void'(sb.pop_back());
      end else if (start && !annul && !busy) begin
        e.res     = ref_div(signed_div, dividend, divisor);
        e.exp_cyc = cyc + 1 + ((divisor == 32'd0) ? 1 : 32);
        sb.push_back(e);
      end
    end
  end

  // Monitor: compare every done pulse against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("reset_outputs", {30'd0, busy, done, result}, 96'd0);
      end else if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 with result %h, required no done", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end else begin
        check("result_idle_zero", result, 64'd0);
        if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_done: got no done by cycle %0d, required at %0d", cyc, sb[0].exp_cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    @(negedge clk);
    #1;
    while (busy && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got busy=1, required idle");
    end
    start      = 1'b1;
    signed_div = s;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    #1;
    start      = 1'b0;
    signed_div = 1'($urandom);
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() > 0) && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (busy || sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, required idle", busy, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n = 1'b0; start = 1'b0; annul = 1'b0;
    signed_div = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    #1;
    // First edge with reset released accepts the request
    rst_n = 1'b1; start = 1'b1; signed_div = 1'b0;
    dividend = 32'hFFFF_FFFB; divisor = 32'd6;
    @(negedge clk);
    #1;
    start = 1'b0;
    check("first_accept_busy", {63'd0, busy}, 64'd1);

    issue(1'b1, 32'hFFFF_FFFB, 32'd6);
    issue(1'b1, 32'd100, 32'hFFFF_FFF9);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'h1234_5678, 32'd0);
    issue(1'b1, 32'hFFFF_FFFD, 32'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_idle();

    // Annul at RUN step 10, then a new request
    issue(1'b0, 32'h1234_5678, 32'h11);
    repeat (10) @(negedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #1;
    annul = 1'b0;
    issue(1'b0, 32'd100, 32'd7);
    wait_idle();

    // Annul has priority over start from IDLE
    @(negedge clk);
    #1;
    start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(negedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    check("annul_priority", {63'd0, busy}, 64'd0);

    // Reset mid-RUN, then a fresh request
    issue(1'b1, $urandom, 32'd3);
    repeat (15) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {62'd0, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    issue(1'b1, 32'hFFFF_FC18, 32'd33);
    wait_idle();

    // Start held high with operands changing every cycle
    repeat (90) begin
      @(negedge clk);
      #1;
      start      = 1'b1;
      signed_div = 1'($urandom);
      dividend   = $urandom;
      divisor    = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
    end
    start = 1'b0;
    wait_idle();

    // Start pulsed while busy must not disturb the running operation
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (20) begin
      @(negedge clk);
      #1;
      start    = 1'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
    end
    start = 1'b0;
    wait_idle();

    // Random mix including corner operands
    repeat (40) begin
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      issue(1'($urandom), a, b);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  Pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset.
REQ-004 start  input  1  Request a division; sampled only in IDLE.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
REQ-006 dividend  input  32  Operand A (rs); captured with start.
REQ-007 divisor  input  32  Operand B (rt); captured with start.
REQ-008 annul  input  1  Pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  High while the state is not IDLE; drives the EX-stage stall request.
REQ-010 done  output  1  One-cycle pulse; result is valid in that cycle.
REQ-011 result  output  64  {remainder, quotient}; the upper word is written to HI and the lower word to LO.

Function
REQ-012 The state machine SHALL have four states: IDLE, ZERO, RUN and END.
REQ-013 In IDLE, with start=1 and annul=0: go to ZERO if divisor==0, otherwise go to RUN; capture the operands and signed_div; clear the iteration counter.
REQ-014 In RUN, perform one restoring radix-2 step per cycle on the operand magnitudes using a 65-bit partial-remainder/quotient register.
REQ-015 After the 32nd RUN step (counter value 31), go to END.
REQ-016 ZERO SHALL go to END on the next edge with result forced to 0.
REQ-017 END SHALL assert done=1 and present result for exactly one cycle, then return to IDLE.
REQ-018 Latency: done is high in the cycle after the 33rd rising edge following the accepting edge for a nonzero divisor, and after the 2nd edge for a zero divisor.
REQ-019 Signed mode: take magnitudes of negative operands; negate the quotient when the operand signs differ; give the remainder the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0 (32-bit wrap, no trap).
REQ-021 Unsigned mode SHALL apply no sign correction.
REQ-022 annul=1 in any state SHALL force IDLE on the next edge; done is not asserted and result is cleared.
REQ-023 annul has priority over start in the same cycle.
REQ-024 start while busy=1 SHALL be ignored; the captured operands stay stable.
REQ-025 start in the END cycle SHALL be ignored; a new start is accepted only from IDLE, at the earliest in the cycle after done.
REQ-026 result SHALL be held at 0 whenever done=0.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, busy=0, done=0, result=0, counter=0, internal operand registers=0.
REQ-028 Reset mid-operation SHALL discard the operation; no done is produced after reset release.
REQ-029 The first start SHALL be accepted on the first rising edge at which reset=1.

Structure
REQ-030 The state encodings and the DATA_WIDTH (32) constant SHALL live in the shared CPU definitions package.
REQ-031 The done, busy and result signals SHALL be shared with the EX stage and the HI/LO write path.
REQ-032 No sub-module SHALL be used; negation and the subtract step are inline datapath.
REQ-033 The counter SHALL be 5 bits wide.

Verification
REQ-034 DIVU 0xFFFFFFFB / 0x00000006 -> done after 33 edges; result {0x00000005, 0x2AAAAAA9}.
REQ-035 DIV 0xFFFFFFFB / 0x00000006 -> result {0xFFFFFFFB, 0x00000000}; DIV 100 / -7 -> {0x00000002, 0xFFFFFFF2}.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; any dividend / 0 -> {0, 0} with done after 2 edges.
REQ-037 annul at RUN step 10 -> busy=0 after the next edge, no done pulse; an immediate new DIVU 100 / 7 -> {2, 14}.
REQ-038 Reset asserted mid-RUN, then start re-issued -> outputs 0 during reset, no stale done, and the correct result for the new operands.
REQ-039 start held high continuously and start pulsed while busy -> exactly one done per accepted operation, with the operands of the accepting cycle.
